serial_magnitude_cmp: RTL and testbench

A bit-serial magnitude comparator that compares two `WIDTH`-bit operands streamed MSB-first, `DIGIT` bits per accepted beat. It supports signed and unsigned modes, a start/done handshake, and input stalls through a valid qualifier. The first differing digit decides the result; the block then consumes the remaining digits without re-evaluating them. It serves as the general-width replacement for the single-bit unsigned serial comparator in the arithmetic datapath.

---
 rtl/cmp_pkg.sv | 30 +++
 rtl/serial_cmp_digit.sv | 25 ++
 rtl/serial_magnitude_cmp.sv | 110 +++++++++++
 tb/tb_serial_magnitude_cmp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result flags are encoded as {lt, eq, gt}.
package cmp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDecided,
        StDone
    } cmp_state_e;

    localparam logic [2:0] ResNone = 3'b000;
    localparam logic [2:0] ResLt   = 3'b100;
    localparam logic [2:0] ResEq   = 3'b010;
    localparam logic [2:0] ResGt   = 3'b001;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice; inv_msb flips both
// MSBs so the top digit of a two's-complement operand orders correctly.
module serial_cmp_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             inv_msb,
    output logic             d_lt,
    output logic             d_gt
);

    logic [DIGIT-1:0] a_x;
    logic [DIGIT-1:0] b_x;

    always_comb begin
        a_x            = a;
        b_x            = b;
        a_x[DIGIT-1]   = a[DIGIT-1] ^ inv_msb;
        b_x[DIGIT-1]   = b[DIGIT-1] ^ inv_msb;
        d_lt           = (a_x < b_x);
        d_gt           = (a_x > b_x);
    end

endmodule

// File: rtl/serial_magnitude_cmp.sv
// MSB-first bit-serial magnitude comparator, DIGIT bits per accepted beat.
// The first differing digit decides; remaining digits are only counted.
module serial_magnitude_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             in_valid,
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = clog2(NDIG + 1);

    cmp_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          smode_q, smode_d;
    logic          lt_r, lt_r_d;
    logic          gt_r, gt_r_d;
    logic          done_q, done_d;
    logic [2:0]    res_q, res_d;

    logic d_lt, d_gt;
    logic accept, last, dec_lt, dec_gt;

    serial_cmp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a       (a_dig),
        .b       (b_dig),
        .inv_msb (smode_q && (cnt_q == '0)),
        .d_lt    (d_lt),
        .d_gt    (d_gt)
    );

    assign accept = ((state_q == StScan) || (state_q == StDecided)) && in_valid && !start;
    assign last   = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smode_d = smode_q;
        lt_r_d  = lt_r;
        gt_r_d  = gt_r;
        done_d  = 1'b0;
        res_d   = res_q;
        dec_lt  = lt_r;
        dec_gt  = gt_r;

        if (start) begin
            // Restart from any state; a partial comparison is abandoned.
            state_d = StScan;
            cnt_d   = '0;
            smode_d = signed_mode;
            lt_r_d  = 1'b0;
            gt_r_d  = 1'b0;
            res_d   = ResNone;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            if ((state_q == StScan) && (d_lt || d_gt)) begin
                state_d = StDecided;
                lt_r_d  = d_lt;
                gt_r_d  = d_gt;
                dec_lt  = d_lt;
                dec_gt  = d_gt;
            end
            if (last) begin
                state_d = StDone;
                done_d  = 1'b1;
                res_d   = dec_lt ? ResLt : (dec_gt ? ResGt : ResEq);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            smode_q <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= ResNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
            lt_r    <= lt_r_d;
            gt_r    <= gt_r_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy         = (state_q == StScan) || (state_q == StDecided);
    assign done         = done_q;
    assign {lt, eq, gt} = res_q;

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// Directed bench: three comparator instances (DIGIT = 1, 4, 8; WIDTH = 32)
// driven from a vector table plus hand-written abort/reset/back-to-back cases.
module tb_serial_magnitude_cmp;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st0, sm0, v0, st1, sm1, v1, st2, sm2, v2;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [4:0] o0, o1, o2;

    int checks   = 0;
    int failures = 0;

    serial_magnitude_cmp #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(st0), .signed_mode(sm0), .in_valid(v0),
        .a_dig(a1), .b_dig(b1), .busy(o0[4]), .done(o0[3]), .lt(o0[2]), .eq(o0[1]),
        .gt(o0[0])
    );
    serial_magnitude_cmp #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(st1), .signed_mode(sm1), .in_valid(v1),
        .a_dig(a4), .b_dig(b4), .busy(o1[4]), .done(o1[3]), .lt(o1[2]), .eq(o1[1]),
        .gt(o1[0])
    );
    serial_magnitude_cmp #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(st2), .signed_mode(sm2), .in_valid(v2),
        .a_dig(a8), .b_dig(b8), .busy(o2[4]), .done(o2[3]), .lt(o2[2]), .eq(o2[1]),
        .gt(o2[0])
    );

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        int          gap;
        logic [2:0]  exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic int dw(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    function automatic logic [4:0] obs(input int k);
        return (k == 0) ? o0 : ((k == 1) ? o1 : o2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: {busy,done,lt,eq,gt} got=%b want=%b", nm, got, exp);
        end
    endtask

    // Drive instance k with control bits and digit i of operands a/b.
    task automatic drive(input int k, input logic s, input logic sm, input logic v,
                         input logic [31:0] a, input logic [31:0] b, input int i);
        logic [31:0] av, bv;
        av = a >> (32 - dw(k) * (i + 1));
        bv = b >> (32 - dw(k) * (i + 1));
        case (k)
            0: begin st0 = s; sm0 = sm; v0 = v; a1 = av[0:0]; b1 = bv[0:0]; end
            1: begin st1 = s; sm1 = sm; v1 = v; a4 = av[3:0]; b4 = bv[3:0]; end
            default: begin st2 = s; sm2 = sm; v2 = v; a8 = av[7:0]; b8 = bv[7:0]; end
        endcase
    endtask

    // Start with a valid, differing junk digit present; it must be ignored.
    task automatic do_start(input int k, input logic sm, input string nm);
        drive(k, 1'b1, sm, 1'b1, 32'hFFFF_FFFF, 32'h0, 0);
        step();
        drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        chk({nm, " start"}, obs(k), 5'b10000);
    endtask

    task automatic feed(input int k, input logic [31:0] a, input logic [31:0] b,
                        input int from, input int to, input int gap, input string nm);
        int nd;
        nd = 32 / dw(k);
        for (int i = from; i < to; i++) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                drive(k, 1'b0, 1'b0, 1'b0, ~a, ~b, i);
                step();
                chk($sformatf("%s stall%0d", nm, i), obs(k), 5'b10000);
            end
            drive(k, 1'b0, 1'b0, 1'b1, a, b, i);
            step();
            if (i != nd - 1) chk($sformatf("%s beat%0d", nm, i), obs(k), 5'b10000);
        end
        drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic run(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input int gap, input logic [2:0] exp, input string nm);
        do_start(k, sm, nm);
        feed(k, a, b, 0, 32 / dw(k), gap, nm);
        chk({nm, " done"}, obs(k), {2'b01, exp});
        // Valid beats in DONE are ignored and the flags hold.
        drive(k, 1'b0, 1'b0, 1'b1, ~a, b, 0);
        step();
        chk({nm, " hold"}, obs(k), {2'b00, exp});
        drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        #3;
        chk("reset d1", o0, 5'b00000);
        chk("reset d4", o1, 5'b00000);
        chk("reset d8", o2, 5'b00000);
        step();
        step();
        rst = 1'b0;
        step();

        vt.push_back('{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0,  GT, "d1 u 8000/7fff"});
        vt.push_back('{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0,  LT, "d1 s 8000/7fff"});
        vt.push_back('{0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0,  GT, "d1 s -1/-2"});
        vt.push_back('{0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 30, GT, "d1 s 7fff/8000"});
        vt.push_back('{0, 32'h0000_0000, 32'h0000_0001, 1'b0, 0,  LT, "d1 u last-bit"});
        vt.push_back('{1, 32'h1234_5678, 32'h1234_5678, 1'b0, 50, EQ, "d4 eq gaps"});
        vt.push_back('{1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0,  LT, "d4 s 8000/7fff"});
        vt.push_back('{1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 20, GT, "d4 u 8000/7fff"});
        vt.push_back('{1, 32'h0000_000F, 32'h0000_000E, 1'b0, 0,  GT, "d4 u last-dig"});
        vt.push_back('{2, 32'h01FF_FFFF, 32'h0200_0000, 1'b0, 0,  LT, "d8 u first-dig"});
        vt.push_back('{2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0,  GT, "d8 s 7fff/8000"});
        vt.push_back('{2, 32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 40, LT, "d8 s -256/-255"});

        foreach (vt[n]) run(vt[n].k, vt[n].a, vt[n].b, vt[n].sm, vt[n].gap, vt[n].exp, vt[n].name);

        // Abort after 10 beats of an lt-deciding pair, then an equal pair.
        do_start(0, 1'b0, "abort");
        feed(0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 10, 0, "abort pre");
        run(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, EQ, "abort fresh");

        // Asynchronous reset mid-scan, then 5 vs 5.
        do_start(0, 1'b0, "rstmid");
        feed(0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 7, 0, "rstmid pre");
        rst = 1'b1;
        #1;
        chk("rstmid async", o0, 5'b00000);
        step();
        chk("rstmid held", o0, 5'b00000);
        rst = 1'b0;
        step();
        chk("rstmid idle", o0, 5'b00000);
        run(0, 32'd5, 32'd5, 1'b0, 0, EQ, "rstmid 5/5");

        // Start coincident with done: one-cycle result, then cleared.
        do_start(2, 1'b0, "b2b");
        feed(2, 32'h0000_0010, 32'h0000_0001, 0, 4, 0, "b2b first");
        chk("b2b done", o2, {2'b01, GT});
        drive(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        step();
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        chk("b2b cleared", o2, 5'b10000);
        feed(2, 32'h0000_0001, 32'h0000_0010, 0, 4, 0, "b2b second");
        chk("b2b second done", o2, {2'b01, LT});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
